// File: rtl/uart_pkg.sv
// Shared UART constants plus the helper that turns a clock/baud pair into a
// fixed-point {integer, fraction} divisor.
package uart_pkg;

  localparam longint CLK       = 50_000_000;
  localparam longint BAUD_RATE = 230_400;
  localparam int     NUM_TICKS = 16;

  // What the generator does on a given enabled/disabled clock edge.
  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_SYNC,
    ACT_BOUNDARY,
    ACT_COUNT
  } action_t;

  // Rounded clk/(baud*os) with frac_bits fractional bits, packed as {int, frac}.
  function automatic longint baud_div(input longint clk, input longint baud,
                                      input longint os, input int frac_bits);
    longint den;
    den = baud * os;
    return ((clk << frac_bits) + den / 2) / den;
  endfunction

endpackage

// File: rtl/frac_acc.sv
// Fractional phase accumulator: adds frac on each step and latches the carry
// that stretches the following period by one clock.
module frac_acc #(
  parameter int N_FRAC = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              step,
  input  logic [N_FRAC-1:0] frac,
  output logic              carry
);

  logic [N_FRAC-1:0] acc;
  logic [N_FRAC:0]   sum;
  logic [N_FRAC:0]   look;

  // The carry is looked ahead from the updated accumulator so that it already
  // governs the period that starts at this boundary.
  always_comb begin
    sum  = {1'b0, acc} + {1'b0, frac};
    look = {1'b0, sum[N_FRAC-1:0]} + {1'b0, frac};
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      acc   <= '0;
      carry <= 1'b0;
    end else if (step) begin
      acc   <= sum[N_FRAC-1:0];
      carry <= look[N_FRAC];
    end
  end

endmodule

// File: rtl/baud_frac_gen.sv
// Fractional baud tick generator: one-cycle oversample tick every
// div_int + div_frac/2^N_FRAC clocks on average, bit_tick every OVERSAMPLE ticks.
module baud_frac_gen
  import uart_pkg::*;
#(
  parameter int N_INT      = 16,
  parameter int N_FRAC     = 4,
  parameter int OVERSAMPLE = 16,
  parameter int DEF_INT    = int'(baud_div(CLK, BAUD_RATE, NUM_TICKS, N_FRAC) >> N_FRAC),
  parameter int DEF_FRAC   = int'(baud_div(CLK, BAUD_RATE, NUM_TICKS, N_FRAC) &
                                  ((longint'(1) << N_FRAC) - 1))
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              sync,
  input  logic [N_INT-1:0]  div_int,
  input  logic [N_FRAC-1:0] div_frac,
  input  logic              div_load,
  output logic              load_pending,
  output logic              tick,
  output logic              bit_tick
);

  localparam int                SUB_W    = $clog2(OVERSAMPLE);
  localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(OVERSAMPLE - 1);
  localparam logic [N_INT-1:0]  RST_INT  = N_INT'(DEF_INT);
  localparam logic [N_FRAC-1:0] RST_FRAC = N_FRAC'(DEF_FRAC);
  localparam logic [N_INT:0]    ONE      = (N_INT+1)'(1);

  logic [N_INT:0]    cnt;
  logic [N_INT:0]    eff_int;
  logic [N_INT:0]    period;
  logic [N_INT-1:0]  act_int;
  logic [N_INT-1:0]  pend_int;
  logic [N_FRAC-1:0] act_frac;
  logic [N_FRAC-1:0] pend_frac;
  logic [SUB_W-1:0]  sub;
  logic              carry;
  logic              pending;
  logic              boundary;
  logic              acc_clear;
  action_t           action;

  // cnt is one bit wider than the divisor so a maximal divisor plus carry fits.
  always_comb begin
    eff_int  = (act_int == '0) ? ONE : {1'b0, act_int};
    period   = eff_int + {{N_INT{1'b0}}, carry};
    boundary = enable && (cnt == period - ONE);
  end

  always_comb begin
    action = ACT_COUNT;
    if (sync)
      action = ACT_SYNC;
    else if (!enable)
      action = ACT_HOLD;
    else if (boundary)
      action = ACT_BOUNDARY;
  end

  // Any divisor change restarts the fractional phase.
  always_comb begin
    acc_clear = sync || (div_load && !enable) ||
                (boundary && (div_load || pending));
  end

  frac_acc #(
    .N_FRAC(N_FRAC)
  ) u_frac_acc (
    .clock(clock),
    .reset(reset),
    .clear(acc_clear),
    .step (boundary),
    .frac (act_frac),
    .carry(carry)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= '0;
      sub       <= '0;
      tick      <= 1'b0;
      bit_tick  <= 1'b0;
      pending   <= 1'b0;
      act_int   <= RST_INT;
      act_frac  <= RST_FRAC;
      pend_int  <= '0;
      pend_frac <= '0;
    end else begin
      tick     <= 1'b0;
      bit_tick <= 1'b0;
      case (action)
        ACT_SYNC: begin
          cnt     <= '0;
          sub     <= '0;
          pending <= 1'b0;
          if (div_load) begin
            act_int  <= div_int;
            act_frac <= div_frac;
          end else if (pending) begin
            act_int  <= pend_int;
            act_frac <= pend_frac;
          end
        end
        ACT_HOLD: begin
          if (div_load) begin
            cnt      <= '0;
            sub      <= '0;
            pending  <= 1'b0;
            act_int  <= div_int;
            act_frac <= div_frac;
          end
        end
        ACT_BOUNDARY: begin
          cnt      <= '0;
          tick     <= 1'b1;
          bit_tick <= (sub == SUB_LAST);
          sub      <= (sub == SUB_LAST) ? '0 : sub + 1'b1;
          pending  <= 1'b0;
          if (div_load) begin
            act_int  <= div_int;
            act_frac <= div_frac;
          end else if (pending) begin
            act_int  <= pend_int;
            act_frac <= pend_frac;
          end
        end
        default: begin
          cnt <= cnt + ONE;
          if (div_load) begin
            pend_int  <= div_int;
            pend_frac <= div_frac;
            pending   <= 1'b1;
          end
        end
      endcase
    end
  end

  assign load_pending = pending;

endmodule
